// File: rtl/coherency_checker_pkg.sv
// Shared constants for the coherency checker: error cause codes and
// per-core tracker state encoding.
package coherency_checker_pkg;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_STALE    = 3'd1;
    localparam logic [2:0] ERR_BOTH     = 3'd2;
    localparam logic [2:0] ERR_OVERLAP  = 3'd3;
    localparam logic [2:0] ERR_SPURIOUS = 3'd4;
    localparam logic [2:0] ERR_TIMEOUT  = 3'd5;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

endpackage

// File: rtl/coherency_core_tracker.sv
// One core's request tracker: IDLE/BUSY FSM, request latches, age counter,
// protocol/timeout detection and the per-core saturating traffic counters.
module coherency_core_tracker
    import coherency_checker_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 2,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_rd_i,
    input  logic              req_wr_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    input  logic              rdy_i,
    input  logic              mem_act_i,
    input  logic              stale_i,
    output logic              cmp_vld_o,
    output logic              cmp_wr_o,
    output logic [ADDR_W-1:0] cmp_addr_o,
    output logic [DATA_W-1:0] cmp_wdata_o,
    output logic [2:0]        err_code_o,
    output logic [ADDR_W-1:0] err_addr_o,
    output logic [CNT_W-1:0]  rd_cnt_o,
    output logic [CNT_W-1:0]  wr_cnt_o,
    output logic [CNT_W-1:0]  mem_cnt_o,
    output logic [CNT_W-1:0]  stale_cnt_o
);
    localparam int AGE_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    // Age saturates at TIMEOUT, so the timeout fires on exactly one cycle.
    localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(TIMEOUT);
    localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [0:0]        state_q, state_d;
    logic              op_wr_q, op_wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [AGE_W-1:0]  age_q, age_d;
    logic [CNT_W-1:0]  rd_cnt_q, wr_cnt_q, mem_cnt_q, stale_cnt_q;
    logic              both, any_req, one_req, timeout;

    assign both    = req_rd_i & req_wr_i;
    assign any_req = req_rd_i | req_wr_i;
    assign one_req = req_rd_i ^ req_wr_i;

    always_comb begin
        state_d     = state_q;
        op_wr_d     = op_wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        age_d       = age_q;
        cmp_vld_o   = 1'b0;
        cmp_wr_o    = op_wr_q;
        cmp_addr_o  = addr_q;
        cmp_wdata_o = wdata_q;
        err_code_o  = ERR_NONE;
        err_addr_o  = req_addr_i;
        timeout     = 1'b0;
        if (state_q == ST_IDLE) begin
            if (both) begin
                err_code_o = ERR_BOTH;
            end else if (one_req) begin
                if (rdy_i) begin
                    cmp_vld_o   = 1'b1;
                    cmp_wr_o    = req_wr_i;
                    cmp_addr_o  = req_addr_i;
                    cmp_wdata_o = req_wdata_i;
                end else begin
                    state_d = ST_BUSY;
                    op_wr_d = req_wr_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    age_d   = '0;
                end
            end else if (rdy_i) begin
                err_code_o = ERR_SPURIOUS;
            end
        end else begin
            if (rdy_i) begin
                cmp_vld_o = 1'b1;
                state_d   = ST_IDLE;
            end else if (age_q != AGE_MAX) begin
                age_d   = age_q + 1'b1;
                timeout = (age_q == AGE_LAST);
            end
            // A new request while BUSY is flagged and otherwise ignored.
            if (both) begin
                err_code_o = ERR_BOTH;
            end else if (any_req) begin
                err_code_o = ERR_OVERLAP;
            end else if (timeout) begin
                err_code_o = ERR_TIMEOUT;
                err_addr_o = addr_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_wr_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            age_q       <= '0;
            rd_cnt_q    <= '0;
            wr_cnt_q    <= '0;
            mem_cnt_q   <= '0;
            stale_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            op_wr_q <= op_wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            age_q   <= age_d;
            if (cmp_vld_o && !cmp_wr_o && rd_cnt_q != CNT_MAX) rd_cnt_q <= rd_cnt_q + 1'b1;
            if (cmp_vld_o && cmp_wr_o && wr_cnt_q != CNT_MAX) wr_cnt_q <= wr_cnt_q + 1'b1;
            if (mem_act_i && mem_cnt_q != CNT_MAX) mem_cnt_q <= mem_cnt_q + 1'b1;
            if (stale_i && stale_cnt_q != CNT_MAX) stale_cnt_q <= stale_cnt_q + 1'b1;
        end
    end

    assign rd_cnt_o    = rd_cnt_q;
    assign wr_cnt_o    = wr_cnt_q;
    assign mem_cnt_o   = mem_cnt_q;
    assign stale_cnt_o = stale_cnt_q;

endmodule

// File: rtl/coherency_checker.sv
// Passive coherency observer: shadow memory of committed writes, per-read
// stale compare, and capture of the first error across all cores.
module coherency_checker
    import coherency_checker_pkg::*;
#(
    parameter int N_CORES = 4,
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 2,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 255,
    parameter int STRICT  = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_CORES-1:0]         i_rd,
    input  logic [N_CORES-1:0]         i_wr,
    input  logic [N_CORES*ADDR_W-1:0]  i_addr,
    input  logic [N_CORES*DATA_W-1:0]  i_wdata,
    input  logic [N_CORES-1:0]         rdy,
    input  logic [N_CORES*DATA_W-1:0]  rdata,
    input  logic [N_CORES-1:0]         rd,
    input  logic [N_CORES-1:0]         wr,
    output logic                       err,
    output logic [2:0]                 err_code,
    output logic [2:0]                 err_core,
    output logic [ADDR_W-1:0]          err_addr,
    output logic [N_CORES*CNT_W-1:0]   rd_cnt,
    output logic [N_CORES*CNT_W-1:0]   wr_cnt,
    output logic [N_CORES*CNT_W-1:0]   mem_cnt,
    output logic [N_CORES*CNT_W-1:0]   stale_cnt
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [N_CORES-1:0]             cmp_vld, cmp_wr, stale;
    logic [N_CORES-1:0][ADDR_W-1:0] cmp_addr, trk_addr, core_addr;
    logic [N_CORES-1:0][DATA_W-1:0] cmp_wdata;
    logic [N_CORES-1:0][2:0]        trk_code, core_code;
    logic [DEPTH-1:0][DATA_W-1:0]   shadow_q, shadow_d;
    logic [DEPTH-1:0]               valid_q, valid_d;
    logic                           err_q, hit;
    logic [2:0]                     err_code_q, err_code_d, err_core_q, err_core_d;
    logic [ADDR_W-1:0]              err_addr_q, err_addr_d;

    for (genvar k = 0; k < N_CORES; k++) begin : g_core
        coherency_core_tracker #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .CNT_W  (CNT_W),
            .TIMEOUT(TIMEOUT)
        ) u_trk (
            .clk        (clk),
            .rst_n      (rst_n),
            .req_rd_i   (i_rd[k]),
            .req_wr_i   (i_wr[k]),
            .req_addr_i (i_addr[k*ADDR_W +: ADDR_W]),
            .req_wdata_i(i_wdata[k*DATA_W +: DATA_W]),
            .rdy_i      (rdy[k]),
            .mem_act_i  (rd[k] | wr[k]),
            .stale_i    (stale[k]),
            .cmp_vld_o  (cmp_vld[k]),
            .cmp_wr_o   (cmp_wr[k]),
            .cmp_addr_o (cmp_addr[k]),
            .cmp_wdata_o(cmp_wdata[k]),
            .err_code_o (trk_code[k]),
            .err_addr_o (trk_addr[k]),
            .rd_cnt_o   (rd_cnt[k*CNT_W +: CNT_W]),
            .wr_cnt_o   (wr_cnt[k*CNT_W +: CNT_W]),
            .mem_cnt_o  (mem_cnt[k*CNT_W +: CNT_W]),
            .stale_cnt_o(stale_cnt[k*CNT_W +: CNT_W])
        );

        // Reads see the shadow as it stood before this cycle's writes.
        assign stale[k] = cmp_vld[k] & ~cmp_wr[k] & valid_q[cmp_addr[k]] &
                          (rdata[k*DATA_W +: DATA_W] != shadow_q[cmp_addr[k]]);
        assign core_code[k] = (STRICT != 0 && stale[k]) ? ERR_STALE : trk_code[k];
        assign core_addr[k] = (STRICT != 0 && stale[k]) ? cmp_addr[k] : trk_addr[k];
    end

    // Ascending core order lets the highest-indexed same-address writer win.
    always_comb begin
        shadow_d = shadow_q;
        valid_d  = valid_q;
        for (int k = 0; k < N_CORES; k++) begin
            if (cmp_vld[k] && cmp_wr[k]) begin
                shadow_d[cmp_addr[k]] = cmp_wdata[k];
                valid_d[cmp_addr[k]]  = 1'b1;
            end
        end
    end

    always_comb begin
        hit        = 1'b0;
        err_code_d = ERR_NONE;
        err_core_d = '0;
        err_addr_d = '0;
        for (int k = N_CORES - 1; k >= 0; k--) begin
            if (core_code[k] != ERR_NONE) begin
                hit        = 1'b1;
                err_code_d = core_code[k];
                err_core_d = 3'(k);
                err_addr_d = core_addr[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        shadow_q <= shadow_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= '0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            err_core_q <= '0;
            err_addr_q <= '0;
        end else begin
            valid_q <= valid_d;
            if (!err_q && hit) begin
                err_q      <= 1'b1;
                err_code_q <= err_code_d;
                err_core_q <= err_core_d;
                err_addr_q <= err_addr_d;
            end
        end
    end

    assign err      = err_q;
    assign err_code = err_code_q;
    assign err_core = err_core_q;
    assign err_addr = err_addr_q;

endmodule

// File: tb/tb_coherency_checker.sv
// Bench for coherency_checker: directed scenarios plus random traffic checked
// against a transaction-level model; STRICT=1 and STRICT=0 instances side by side.
module tb_coherency_checker;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int AW = 2;
    localparam int CW = 16;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N-1:0]    i_rd = '0, i_wr = '0, rdy = '0, rd = '0, wr = '0;
    logic [N*AW-1:0] i_addr = '0;
    logic [N*DW-1:0] i_wdata = '0, rdata = '0;

    logic            s_err, l_err;
    logic [2:0]      s_code, l_code, s_core, l_core;
    logic [AW-1:0]   s_eaddr, l_eaddr;
    logic [N*CW-1:0] s_rd, s_wr, s_mem, s_stale, l_rd, l_wr, l_mem, l_stale;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    coherency_checker #(.N_CORES(N), .DATA_W(DW), .ADDR_W(AW), .CNT_W(CW), .TIMEOUT(TO), .STRICT(1)) u_strict (
        .clk(clk), .rst_n(rst_n), .i_rd(i_rd), .i_wr(i_wr), .i_addr(i_addr), .i_wdata(i_wdata),
        .rdy(rdy), .rdata(rdata), .rd(rd), .wr(wr),
        .err(s_err), .err_code(s_code), .err_core(s_core), .err_addr(s_eaddr),
        .rd_cnt(s_rd), .wr_cnt(s_wr), .mem_cnt(s_mem), .stale_cnt(s_stale));

    coherency_checker #(.N_CORES(N), .DATA_W(DW), .ADDR_W(AW), .CNT_W(CW), .TIMEOUT(TO), .STRICT(0)) u_loose (
        .clk(clk), .rst_n(rst_n), .i_rd(i_rd), .i_wr(i_wr), .i_addr(i_addr), .i_wdata(i_wdata),
        .rdy(rdy), .rdata(rdata), .rd(rd), .wr(wr),
        .err(l_err), .err_code(l_code), .err_core(l_core), .err_addr(l_eaddr),
        .rd_cnt(l_rd), .wr_cnt(l_wr), .mem_cnt(l_mem), .stale_cnt(l_stale));

    // Reference model: outstanding transaction per core, golden memory, first error.
    int m_rd[N], m_wr[N], m_mem[N], m_stale[N];
    bit m_busy[N], m_op[N];
    int m_addr[N], m_data[N], m_age[N];
    int m_sh[1<<AW];
    bit m_v[1<<AW];
    bit ms_err, ml_err;
    int ms_code, ms_core, ms_addr, ml_code, ml_core, ml_addr;

    function automatic int cnt(input logic [N*CW-1:0] v, input int k);
        return int'(v[k*CW +: CW]);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_rd[k] = 0; m_wr[k] = 0; m_mem[k] = 0; m_stale[k] = 0;
            m_busy[k] = 0; m_op[k] = 0; m_addr[k] = 0; m_data[k] = 0; m_age[k] = 0;
        end
        for (int a = 0; a < (1<<AW); a++) begin
            m_sh[a] = 0; m_v[a] = 0;
        end
        ms_err = 0; ms_code = 0; ms_core = 0; ms_addr = 0;
        ml_err = 0; ml_code = 0; ml_core = 0; ml_addr = 0;
    endtask

    task automatic model_step();
        int code[N], eaddr[N], ca[N], cd[N];
        bit cv[N], cw[N], st[N];
        for (int k = 0; k < N; k++) begin
            int a;
            a = int'(i_addr[k*AW +: AW]);
            code[k] = 0; eaddr[k] = a; cv[k] = 0; cw[k] = 0; ca[k] = 0; cd[k] = 0; st[k] = 0;
            if (rd[k] || wr[k]) m_mem[k]++;
            if (!m_busy[k]) begin
                if (i_rd[k] && i_wr[k]) code[k] = 2;
                else if (i_rd[k] || i_wr[k]) begin
                    if (rdy[k]) begin
                        cv[k] = 1; cw[k] = i_wr[k]; ca[k] = a; cd[k] = int'(i_wdata[k*DW +: DW]);
                    end else begin
                        m_busy[k] = 1; m_op[k] = i_wr[k]; m_addr[k] = a;
                        m_data[k] = int'(i_wdata[k*DW +: DW]); m_age[k] = 0;
                    end
                end else if (rdy[k]) code[k] = 4;
            end else begin
                if (i_rd[k] && i_wr[k]) code[k] = 2;
                else if (i_rd[k] || i_wr[k]) code[k] = 3;
                if (rdy[k]) begin
                    cv[k] = 1; cw[k] = m_op[k]; ca[k] = m_addr[k]; cd[k] = m_data[k]; m_busy[k] = 0;
                end else begin
                    m_age[k]++;
                    if (m_age[k] == TO && code[k] == 0) begin
                        code[k] = 5; eaddr[k] = m_addr[k];
                    end
                end
            end
        end
        for (int k = 0; k < N; k++) begin
            if (cv[k] && !cw[k]) begin
                m_rd[k]++;
                if (m_v[ca[k]] && int'(rdata[k*DW +: DW]) != m_sh[ca[k]]) begin
                    st[k] = 1; m_stale[k]++;
                end
            end
        end
        for (int k = 0; k < N; k++) begin
            if (cv[k] && cw[k]) begin
                m_wr[k]++; m_sh[ca[k]] = cd[k]; m_v[ca[k]] = 1;
            end
        end
        for (int k = 0; k < N; k++) begin
            int sc, sa;
            sc = st[k] ? 1 : code[k];
            sa = st[k] ? ca[k] : eaddr[k];
            if (!ms_err && sc != 0) begin
                ms_err = 1; ms_code = sc; ms_core = k; ms_addr = sa;
            end
            if (!ml_err && code[k] != 0) begin
                ml_err = 1; ml_code = code[k]; ml_core = k; ml_addr = eaddr[k];
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        i_rd = '0; i_wr = '0; rdy = '0; rd = '0; wr = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        i_rd = '0; i_wr = '0; rdy = '0; rd = '0; wr = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic set_req(input int k, input bit r, input bit w, input int a, input int d);
        i_rd[k] = r;
        i_wr[k] = w;
        i_addr[k*AW +: AW] = AW'(a);
        i_wdata[k*DW +: DW] = DW'(d);
    endtask

    task automatic set_rdy(input int k, input int d);
        rdy[k] = 1'b1;
        rdata[k*DW +: DW] = DW'(d);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_req(1, 1, 0, 2, 0);
        set_rdy(1, 'hAA);
        rd = '1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({s_err, s_code, s_core, s_eaddr} !== '0) begin errors++; $display("FAIL reset_err_s got %b want 0", {s_err, s_code, s_core, s_eaddr}); end
        checks++; if ({l_err, l_code, l_core, l_eaddr} !== '0) begin errors++; $display("FAIL reset_err_l got %b want 0", {l_err, l_code, l_core, l_eaddr}); end
        checks++; if ({s_rd, s_wr, s_mem, s_stale} !== '0) begin errors++; $display("FAIL reset_cnt_s got %h want 0", {s_rd, s_wr, s_mem, s_stale}); end
        checks++; if ({l_rd, l_wr, l_mem, l_stale} !== '0) begin errors++; $display("FAIL reset_cnt_l got %h want 0", {l_rd, l_wr, l_mem, l_stale}); end
    endtask

    task automatic write_5a_addr1();
        set_req(0, 0, 1, 1, 'h5A); tick();
        tick();
        set_rdy(0, 0); tick();
    endtask

    task automatic test_write_read();
        do_reset();
        write_5a_addr1();
        set_req(2, 1, 0, 1, 0); tick();
        set_rdy(2, 'h5A); tick();
        checks++; if (cnt(s_wr, 0) != 1) begin errors++; $display("FAIL wr_cnt0 got %0d want 1", cnt(s_wr, 0)); end
        checks++; if (cnt(s_rd, 2) != 1) begin errors++; $display("FAIL rd_cnt2 got %0d want 1", cnt(s_rd, 2)); end
        checks++; if (s_stale !== '0) begin errors++; $display("FAIL stale_none got %h want 0", s_stale); end
        checks++; if (s_err !== 1'b0) begin errors++; $display("FAIL wr_rd_err got %b want 0", s_err); end
    endtask

    task automatic test_stale();
        do_reset();
        write_5a_addr1();
        set_req(3, 1, 0, 1, 0); tick();
        set_rdy(3, 'h00); tick();
        checks++; if (cnt(s_stale, 3) != 1) begin errors++; $display("FAIL stale3_s got %0d want 1", cnt(s_stale, 3)); end
        checks++; if ({s_err, s_code, s_core, s_eaddr} !== {1'b1, 3'd1, 3'd3, 2'd1})
            begin errors++; $display("FAIL stale_err got err=%b code=%0d core=%0d addr=%0d want 1/1/3/1", s_err, s_code, s_core, s_eaddr); end
        checks++; if (cnt(l_stale, 3) != 1) begin errors++; $display("FAIL stale3_l got %0d want 1", cnt(l_stale, 3)); end
        checks++; if (l_err !== 1'b0) begin errors++; $display("FAIL loose_err got %b want 0", l_err); end
    endtask

    task automatic test_same_cycle_writes();
        do_reset();
        set_req(1, 0, 1, 2, 'h11); set_req(3, 0, 1, 2, 'h33); tick();
        set_rdy(1, 0); set_rdy(3, 0); tick();
        set_req(0, 1, 0, 2, 0); set_rdy(0, 'h33); tick();
        checks++; if (s_err !== 1'b0 || s_stale !== '0) begin errors++; $display("FAIL hi_core_wins got err=%b stale=%h want 0", s_err, s_stale); end
        // Read sees pre-write value while core1 overwrites the same address.
        set_req(0, 1, 0, 2, 0); set_rdy(0, 'h33);
        set_req(1, 0, 1, 2, 'h77); set_rdy(1, 0); tick();
        checks++; if (s_err !== 1'b0 || cnt(s_rd, 0) != 2) begin errors++; $display("FAIL rd_before_wr got err=%b rd0=%0d want 0/2", s_err, cnt(s_rd, 0)); end
        set_req(0, 1, 0, 2, 0); set_rdy(0, 'h11); tick();
        checks++; if (cnt(s_stale, 0) != 1) begin errors++; $display("FAIL stale0 got %0d want 1", cnt(s_stale, 0)); end
        checks++; if ({s_err, s_code, s_core, s_eaddr} !== {1'b1, 3'd1, 3'd0, 2'd2})
            begin errors++; $display("FAIL stale0_err got err=%b code=%0d core=%0d addr=%0d want 1/1/0/2", s_err, s_code, s_core, s_eaddr); end
    endtask

    task automatic test_protocol();
        do_reset();
        set_req(1, 1, 1, 3, 0); tick();
        checks++; if ({s_err, s_code, s_core, s_eaddr} !== {1'b1, 3'd2, 3'd1, 2'd3})
            begin errors++; $display("FAIL both got err=%b code=%0d core=%0d addr=%0d want 1/2/1/3", s_err, s_code, s_core, s_eaddr); end
        checks++; if (cnt(s_rd, 1) != 0 || cnt(s_wr, 1) != 0) begin errors++; $display("FAIL both_nocnt got rd=%0d wr=%0d want 0", cnt(s_rd, 1), cnt(s_wr, 1)); end
        do_reset();
        set_req(3, 1, 1, 0, 0); i_addr[1*AW +: AW] = 2'd2; set_rdy(1, 0); tick();
        checks++; if ({l_err, l_code, l_core, l_eaddr} !== {1'b1, 3'd4, 3'd1, 2'd2})
            begin errors++; $display("FAIL low_core got err=%b code=%0d core=%0d addr=%0d want 1/4/1/2", l_err, l_code, l_core, l_eaddr); end
        do_reset();
        set_req(0, 1, 0, 1, 0); tick();
        set_req(0, 0, 1, 2, 'h99); tick();
        checks++; if ({s_err, s_code, s_core, s_eaddr} !== {1'b1, 3'd3, 3'd0, 2'd2})
            begin errors++; $display("FAIL overlap got err=%b code=%0d core=%0d addr=%0d want 1/3/0/2", s_err, s_code, s_core, s_eaddr); end
        set_rdy(2, 0); tick();
        checks++; if (s_code !== 3'd3 || s_core !== 3'd0) begin errors++; $display("FAIL first_only got code=%0d core=%0d want 3/0", s_code, s_core); end
    endtask

    task automatic test_timeout();
        do_reset();
        set_req(2, 1, 0, 3, 0); tick();
        repeat (TO - 1) tick();
        set_rdy(2, 0); tick();
        checks++; if (s_err !== 1'b0 || cnt(s_rd, 2) != 1) begin errors++; $display("FAIL rdy_at_limit got err=%b rd2=%0d want 0/1", s_err, cnt(s_rd, 2)); end
        do_reset();
        set_req(2, 1, 0, 3, 0); tick();
        repeat (TO - 1) tick();
        checks++; if (s_err !== 1'b0) begin errors++; $display("FAIL timeout_early got %b want 0", s_err); end
        tick();
        checks++; if ({s_err, s_code, s_core, s_eaddr} !== {1'b1, 3'd5, 3'd2, 2'd3})
            begin errors++; $display("FAIL timeout got err=%b code=%0d core=%0d addr=%0d want 1/5/2/3", s_err, s_code, s_core, s_eaddr); end
        set_rdy(2, 0); tick();
        checks++; if (cnt(s_rd, 2) != 1) begin errors++; $display("FAIL timeout_busy got rd2=%0d want 1", cnt(s_rd, 2)); end
    endtask

    task automatic test_mem();
        do_reset();
        rd[2] = 1'b1; tick();
        wr[2] = 1'b1; tick();
        rd[2] = 1'b1; wr[2] = 1'b1; tick();
        tick();
        checks++; if (cnt(s_mem, 2) != 3 || cnt(s_mem, 1) != 0) begin errors++; $display("FAIL mem_cnt got m2=%0d m1=%0d want 3/0", cnt(s_mem, 2), cnt(s_mem, 1)); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_req(0, 0, 1, 1, 'h5A); set_rdy(0, 0);
        set_req(1, 1, 0, 0, 0); set_rdy(2, 0); tick();
        checks++; if (s_err !== 1'b1) begin errors++; $display("FAIL pre_reset_err got %b want 1", s_err); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({s_err, s_code, s_core, s_eaddr, s_rd, s_wr, s_mem, s_stale} !== '0)
            begin errors++; $display("FAIL async_reset got err=%b wr=%h want 0", s_err, s_wr); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        set_req(0, 1, 0, 1, 0); set_rdy(0, 'hC3); tick();
        checks++; if (s_err !== 1'b0 || s_stale !== '0 || cnt(s_rd, 0) != 1)
            begin errors++; $display("FAIL valid_cleared got err=%b stale=%h rd0=%0d want 0/0/1", s_err, s_stale, cnt(s_rd, 0)); end
    endtask

    task automatic test_random(input int cycles);
        do_reset();
        for (int c = 0; c < cycles; c++) begin
            for (int k = 0; k < N; k++) begin
                int a, d, ca;
                bit done;
                done = 0; ca = 0;
                rd[k] = ($urandom_range(3) == 0);
                wr[k] = ($urandom_range(3) == 0);
                if (!m_busy[k]) begin
                    if ($urandom_range(99) < 35) begin
                        a = $urandom_range(3); d = $urandom_range(255);
                        if ($urandom_range(1) == 1) set_req(k, 0, 1, a, d);
                        else set_req(k, 1, 0, a, d);
                        ca = a;
                        done = ($urandom_range(99) < 30);
                    end else if ($urandom_range(199) == 0) begin
                        set_req(k, 1, 1, $urandom_range(3), 0);
                    end else if ($urandom_range(199) == 0) begin
                        set_rdy(k, 0);
                    end
                end else begin
                    ca = m_addr[k];
                    done = ($urandom_range(2) == 0);
                end
                if (done) begin
                    d = (m_v[ca] && $urandom_range(1) == 1) ? m_sh[ca] : int'($urandom_range(255));
                    set_rdy(k, d);
                end
            end
            tick();
            for (int k = 0; k < N; k++) begin
                checks++; if (cnt(s_rd, k) != m_rd[k]) begin errors++; $display("FAIL rnd_rd%0d c%0d got %0d want %0d", k, c, cnt(s_rd, k), m_rd[k]); end
                checks++; if (cnt(s_wr, k) != m_wr[k]) begin errors++; $display("FAIL rnd_wr%0d c%0d got %0d want %0d", k, c, cnt(s_wr, k), m_wr[k]); end
                checks++; if (cnt(s_mem, k) != m_mem[k]) begin errors++; $display("FAIL rnd_mem%0d c%0d got %0d want %0d", k, c, cnt(s_mem, k), m_mem[k]); end
                checks++; if (cnt(s_stale, k) != m_stale[k]) begin errors++; $display("FAIL rnd_stale%0d c%0d got %0d want %0d", k, c, cnt(s_stale, k), m_stale[k]); end
            end
            checks++; if ({s_err, s_code, s_core, s_eaddr} !== {ms_err, 3'(ms_code), 3'(ms_core), 2'(ms_addr)})
                begin errors++; $display("FAIL rnd_err_s c%0d got %b/%0d/%0d/%0d want %b/%0d/%0d/%0d", c, s_err, s_code, s_core, s_eaddr, ms_err, ms_code, ms_core, ms_addr); end
            checks++; if ({l_err, l_code, l_core, l_eaddr} !== {ml_err, 3'(ml_code), 3'(ml_core), 2'(ml_addr)})
                begin errors++; $display("FAIL rnd_err_l c%0d got %b/%0d/%0d/%0d want %b/%0d/%0d/%0d", c, l_err, l_code, l_core, l_eaddr, ml_err, ml_code, ml_core, ml_addr); end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_stale();
        test_same_cycle_writes();
        test_protocol();
        test_timeout();
        test_mem();
        test_reset_mid();
        test_random(300);
        test_random(300);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/coherency_checker.md
Name: coherency_checker

Overview:
- Parametrised, synthesizable successor to the per-core passive monitor.
- Observes N_CORES CPU-side cache ports plus their memory-side rd/wr strobes.
- Keeps a golden shadow memory of the last committed write per address and checks every completed read against it.
- Counts traffic and stale reads per core, and detects protocol violations and hung requests.
- Sits beside the cache cluster in the coherency testbench/FPGA top.
- Drives nothing into the DUT; pure observer with status outputs.

Parameters:
- N_CORES, 4, number of observed cores (2..8)
- DATA_W, 8, data width
- ADDR_W, 2, address width; shadow memory has 2**ADDR_W entries
- CNT_W, 16, width of every counter; counters saturate
- TIMEOUT, 255, max cycles from request to rdy; 0 disables
- STRICT, 1, 1: stale read raises error; 0: stale read only counted (non-coherent configs)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_rd  in  N_CORES  CPU read request per core, one-cycle pulse
- i_wr  in  N_CORES  CPU write request per core, one-cycle pulse
- i_addr  in  N_CORES*ADDR_W  request address, core k at [k*ADDR_W +: ADDR_W]
- i_wdata  in  N_CORES*DATA_W  write data, valid with i_wr
- rdy  in  N_CORES  request completion pulse per core
- rdata  in  N_CORES*DATA_W  read data, valid with rdy
- rd  in  N_CORES  memory-side read strobe per core
- wr  in  N_CORES  memory-side write strobe per core
- err  out  1  sticky error flag
- err_code  out  3  first error cause
- err_core  out  3  core index of first error
- err_addr  out  ADDR_W  address of first error
- rd_cnt  out  N_CORES*CNT_W  completed CPU reads per core
- wr_cnt  out  N_CORES*CNT_W  completed CPU writes per core
- mem_cnt  out  N_CORES*CNT_W  cycles with rd|wr high per core
- stale_cnt  out  N_CORES*CNT_W  stale reads per core

Behaviour:
- Reset (rst_n low, async): all outputs 0; all trackers IDLE; all shadow valid bits cleared; shadow data is don't-care.
- Tracker per core, states IDLE, BUSY:
  - IDLE + (i_rd xor i_wr) -> BUSY; latch op, addr, wdata; clear age counter.
  - BUSY + rdy -> IDLE; complete op.
  - rdy in the request cycle itself is a completion with zero latency; the tracker stays IDLE.
- Write completion: shadow[addr] <= wdata; valid <= 1; wr_cnt++.
- Read completion: rd_cnt++.
  - If valid[addr] and rdata != shadow[addr]: stale_cnt++.
  - If STRICT, also raise error code 1 (STALE).
  - A read of an invalid address never mismatches.
- Same-cycle events:
  - Reads are compared against the shadow value from before the current cycle's writes.
  - Multiple writes completing to one address: the highest core index wins.
- Protocol errors (tracker state unchanged):
  - i_rd & i_wr both high: code 2 (BOTH).
  - New request while BUSY: code 3 (OVERLAP).
  - rdy while IDLE and no request this cycle: code 4 (SPURIOUS).
- Timeout: BUSY age reaching TIMEOUT raises code 5 (TIMEOUT) once; the tracker stays BUSY.
- Error capture: err goes high the cycle after the first error and stays high until reset.
  - err_code, err_core, err_addr capture that first error only.
  - For same-cycle errors, the lowest core index is captured; within a core, the lowest code.
- Counters: saturate at 2**CNT_W-1; never wrap; all outputs are registered.
- Latency: every output reflects its triggering event one cycle later.

Decomposition:
- Package coherency_checker_pkg holds the ERR_NONE/STALE/BOTH/OVERLAP/SPURIOUS/TIMEOUT 3-bit constants and the tracker state constants.
- One sub-module, coherency_core_tracker, instantiated N_CORES times in a generate loop.
  - Handles one core's FSM, latches, age counter, protocol/timeout detection and saturating counters.
- The top holds the shadow memory, the compare and the first-error arbitration.

Test Plan (N_CORES=4, DATA_W=8, ADDR_W=2, TIMEOUT=8, STRICT=1):
- Core0 writes 0x5A to addr 1 (rdy after 2 cycles); core2 reads addr 1 and returns 0x5A -> wr_cnt[0]=1, rd_cnt[2]=1, stale_cnt=0, err=0.
- Same write, then core3 reads addr 1 and returns 0x00 -> stale_cnt[3]=1, err=1, err_code=1, err_core=3, err_addr=1.
- Rerun the previous case with STRICT=0 -> stale_cnt[3]=1, err stays 0.
- Core1 and core3 write 0x11/0x33 to addr 2 completing in the same cycle; core0 then reads 0x33 -> no error. Core0 reading 0x11 instead -> stale.
- Core1 raises i_rd and i_wr together -> err_code=2, err_core=1. Separately, core2 issues i_rd with no rdy for 8 cycles -> err_code=5, err_core=2.
- Assert rst_n low mid-BUSY with err=1 -> all outputs 0 immediately. After release, a core0 read of addr 1 returning any value -> no stale, because the valid bits are cleared.
